// File: rtl/mips_datapath_memory_arbiter_if.sv
// Core, host and data-RAM signal bundle for the MIPS data-memory arbiter.
// The arbiter uses the slave modport; the requesters and RAM model use master.
interface mips_datapath_memory_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_stall;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic [DATA_W-1:0] ram_out;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  ram_out,
    output core_stall, core_rdata, host_ack, host_rdata,
    output ram_addr, ram_data, ram_we
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output ram_out,
    input  core_stall, core_rdata, host_ack, host_rdata,
    input  ram_addr, ram_data, ram_we
  );
endinterface

// File: rtl/mips_datapath_memory_arbiter.sv
// Round-robin data-RAM arbiter between the MIPS core and a host loader/debug port.
// Define MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN to enable the host port; otherwise the core owns the RAM.
module mips_datapath_memory_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input logic                           clock,
  input logic                           reset,
  mips_datapath_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic CORE = 1'b0;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
  localparam logic HOST = 1'b1;
`endif

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] core_rdata_q;

  logic              resp_core;
  logic              core_pend;
  logic              host_pend;
  logic              grant;
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
  logic              last_q;
  logic              resp_host;
  logic [DATA_W-1:0] host_rdata_q;
`endif

  // Arbitration: the owner completing in RESP has its request consumed this cycle.
  always_comb begin
    resp_core = (state_q == RESP) && (owner_q == CORE);
    core_pend = bus.core_req && !resp_core;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
    resp_host = (state_q == RESP) && (owner_q == HOST);
    host_pend = bus.host_req && !resp_host;
    if (core_pend && host_pend) begin
      win = (last_q == CORE) ? HOST : CORE;
    end else begin
      win = host_pend ? HOST : CORE;
    end
    sel_we    = (win == HOST) ? bus.host_we    : bus.core_we;
    sel_addr  = (win == HOST) ? bus.host_addr  : bus.core_addr;
    sel_wdata = (win == HOST) ? bus.host_wdata : bus.core_wdata;
`else
    host_pend = 1'b0;
    win       = CORE;
    sel_we    = bus.core_we;
    sel_addr  = bus.core_addr;
    sel_wdata = bus.core_wdata;
`endif
    grant = (state_q != ACCESS) && (core_pend || host_pend);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= CORE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant) begin
          state_d = ACCESS;
          owner_d = win;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request latch doubles as the RAM drive; ram_we is high only for the ACCESS cycle of a store.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      ram_we_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
      last_q       <= HOST;
      host_rdata_q <= '0;
`endif
    end else begin
      ram_we_q <= 1'b0;
      if (grant) begin
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        ram_we_q <= sel_we;
      end
      if (resp_core && !we_q) begin
        core_rdata_q <= bus.ram_out;
      end
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
      if (state_q == RESP) begin
        last_q <= owner_q;
      end
      if (resp_host && !we_q) begin
        host_rdata_q <= bus.ram_out;
      end
`endif
    end
  end

  // Load data is forwarded straight from the RAM during RESP, then held in the owner's register.
  always_comb begin
    bus.core_stall = bus.core_req && !resp_core;
    bus.core_rdata = (resp_core && !we_q) ? bus.ram_out : core_rdata_q;
    bus.ram_addr   = addr_q;
    bus.ram_data   = wdata_q;
    bus.ram_we     = ram_we_q;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
    bus.host_ack   = resp_host;
    bus.host_rdata = (resp_host && !we_q) ? bus.ram_out : host_rdata_q;
`else
    bus.host_ack   = 1'b0;
    bus.host_rdata = '0;
`endif
  end

endmodule

// File: tb/tb_mips_datapath_memory_arbiter.sv
// Scoreboard bench for the MIPS data-memory arbiter: drivers queue expected completions,
// a negedge monitor pops and checks latency and read data whenever a requester completes.
module tb_mips_datapath_memory_arbiter;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lmin;
    int          lmax;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mips_datapath_memory_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mips_datapath_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t q_core[$];
  exp_t q_host[$];
  int   vec = 0;
  int   miss = 0;
  int   cyc = 0;
  bit   alt_on = 1'b0;
  bit   alt_valid = 1'b0;
  bit   alt_last_host = 1'b0;

  // Synchronous RAM model: read data valid one cycle after the address is sampled.
  logic [DATA_W-1:0] mem [0:511];
  logic [DATA_W-1:0] ram_out_r;
  bit                filled = 1'b0;

  always @(posedge clock) begin
    if (!filled) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem[5] <= 32'hDEAD_BEEF;
      filled <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
    ram_out_r <= mem[bus.ram_addr];
  end
  assign bus.ram_out = ram_out_r;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int val, input int lo, input int hi);
    vec++;
    if (val < lo || val > hi) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, val, lo, hi, cyc);
    end
  endtask

  task automatic alt_check(input bit is_host);
    if (alt_on) begin
      if (alt_valid) chk(is_host ? "alt_host" : "alt_core", 32'(alt_last_host), 32'(!is_host));
      alt_valid = 1'b1;
    end else begin
      alt_valid = 1'b0;
    end
    alt_last_host = is_host;
  endtask

  // Monitor: a completion is core_req with stall low, or a host_ack pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (bus.core_req && !bus.core_stall) begin
        if (q_core.size() == 0) begin
          chk("core_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q_core.pop_front();
          chk_rng("core_latency", cyc - e.issue, e.lmin, e.lmax);
          chk("core_rdata", bus.core_rdata, e.data);
`ifndef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
          chk("host_ack_off", 32'(bus.host_ack), 32'd0);
          chk("host_rdata_off", bus.host_rdata, 32'd0);
`endif
          alt_check(1'b0);
        end
      end
      if (bus.host_ack) begin
        if (q_host.size() == 0) begin
          chk("host_unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = q_host.pop_front();
          chk_rng("host_latency", cyc - e.issue, e.lmin, e.lmax);
          chk("host_rdata", bus.host_rdata, e.data);
          alt_check(1'b1);
        end
      end
    end
  end

  // One access; called just after a rising edge, returns just after the edge following completion.
  task automatic access(input bit host, input bit we, input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input int lmin, input int lmax, input bit keep);
    int n;
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
      q_host.push_back('{exp_rd, cyc, lmin, lmax});
    end else begin
      bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
      q_core.push_back('{exp_rd, cyc, lmin, lmax});
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((host ? !bus.host_ack : bus.core_stall) && n < 20);
    if (n >= 20) chk(host ? "host_timeout" : "core_timeout", 32'd1, 32'd0);
    @(posedge clock);
    #1;
    if (!keep) begin
      if (host) bus.host_req = 1'b0;
      else      bus.core_req = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Store of all-ones to address 9, aborted by reset while in ACCESS.
  task automatic abort_store(input bit host);
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 9'd9; bus.host_wdata = 32'hFFFF_FFFF;
    end else begin
      bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 9'd9; bus.core_wdata = 32'hFFFF_FFFF;
    end
    @(posedge clock);
    #1;
    chk("abort_ram_we_in_access", 32'(bus.ram_we), 32'd1);
    chk("abort_ram_addr_in_access", 32'(bus.ram_addr), 32'd9);
    reset = 1'b1;
    #1;
    chk("abort_ram_we_drop", 32'(bus.ram_we), 32'd0);
    chk("abort_host_ack", 32'(bus.host_ack), 32'd0);
    if (host) bus.host_req = 1'b0;
    else      bus.core_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("abort_mem9_kept", mem[9], 32'hA5A5_0009);
    chk("abort_rdata_cleared", host ? bus.host_rdata : bus.core_rdata, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
    bus.host_req = 1'b0;
`else
    bus.host_req = 1'b1;
`endif
    bus.host_we = 1'b1; bus.host_addr = 9'd7; bus.host_wdata = 32'h5555_AAAA;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_data", bus.ram_data, 32'd0);
    chk("rst_core_rdata", bus.core_rdata, 32'd0);
    chk("rst_host_rdata", bus.host_rdata, 32'd0);
    chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_core_stall", 32'(bus.core_stall), 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    access(1'b0, 1'b0, 9'd5,   32'h0,         32'hDEAD_BEEF, 2, 2, 1'b0);
    access(1'b0, 1'b1, 9'd7,   32'h1234_5678, 32'hDEAD_BEEF, 2, 2, 1'b0);
    access(1'b0, 1'b0, 9'd7,   32'h0,         32'h1234_5678, 2, 2, 1'b0);
    access(1'b0, 1'b0, 9'd3,   32'h0,         32'hA5A5_0003, 2, 2, 1'b1);
    access(1'b0, 1'b0, 9'd4,   32'h0,         32'hA5A5_0004, 2, 2, 1'b0);
    access(1'b0, 1'b1, 9'd511, 32'hCAFE_F00D, 32'hA5A5_0004, 2, 2, 1'b0);
    access(1'b0, 1'b0, 9'd511, 32'h0,         32'hCAFE_F00D, 2, 2, 1'b0);
    access(1'b0, 1'b0, 9'd0,   32'h0,         32'hA5A5_0000, 2, 2, 1'b0);

    abort_store(1'b0);
    access(1'b0, 1'b0, 9'd9, 32'h0, 32'hA5A5_0009, 2, 2, 1'b0);

`ifdef MIPS_DATAPATH_MEMORY_ARBITER_HOST_EN
    access(1'b1, 1'b1, 9'd20, 32'h0BAD_C0DE, 32'h0,         2, 2, 1'b0);
    access(1'b0, 1'b0, 9'd20, 32'h0,         32'h0BAD_C0DE, 2, 2, 1'b0);

    pulse_reset();
    fork
      access(1'b0, 1'b0, 9'd3, 32'h0, 32'hA5A5_0003, 2, 2, 1'b0);
      access(1'b1, 1'b0, 9'd4, 32'h0, 32'hA5A5_0004, 4, 4, 1'b0);
    join

    alt_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) access(1'b0, 1'b0, 9'd3, 32'h0, 32'hA5A5_0003, 2, 4, i < 3);
      end
      begin
        for (int j = 0; j < 4; j++) access(1'b1, 1'b0, 9'd5, 32'h0, 32'hDEAD_BEEF, 2, 4, j < 3);
      end
    join
    alt_on = 1'b0;

    abort_store(1'b1);
    access(1'b1, 1'b0, 9'd9, 32'h0, 32'hA5A5_0009, 2, 2, 1'b0);
`endif

    repeat (3) @(posedge clock);
    #1;
    chk("core_queue_drained", 32'(q_core.size()), 32'd0);
    chk("host_queue_drained", 32'(q_host.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
